instr_decoder: RTL and testbench
================================

Name: instr_decoder

Overview:
- Registered RV32IM decode stage. Accepts raw 32-bit instruction words from fetch and produces the one-hot operation vector, register addresses, sign-extended immediate and enable flags consumed by the ALU and register file.
- Sits between the fetch stage and the execute stage (ALU).
- Uses a valid/ready handshake on both sides. A 2-entry skid buffer keeps in_ready a registered signal.

Parameters:
- XLEN, 32, data/immediate/PC width
- OPV_W, 48, one-hot operation vector width; bits 0..47. The ALU instructions port is widened to match so that remu at bit 47 reaches it.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  fetch presents instr_in/pc_in
- in_ready  output  1  decoder can accept; registered
- instr_in  input  32  raw instruction word
- pc_in  input  XLEN  PC of instr_in
- flush  input  1  discard all held and incoming instructions
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute stage accepts bundle
- instructions  output  OPV_W  one-hot operation vector; all-zero if illegal
- rs1_addr  output  5  source register 1 index
- rs2_addr  output  5  source register 2 index
- rd_addr  output  5  destination index
- imm  output  XLEN  sign-extended immediate (the ALU uses imm[11:0] or imm[4:0])
- alu_enable  output  1  drives ALUenabled
- rd_write  output  1  writeback required; 0 if rd=0
- pc_out  output  XLEN  PC of the bundle
- illegal  output  1  unrecognised encoding

Behaviour:
- One-hot map, fixed in the package:
  - 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu
  - 10 addi, 11 xori, 12 ori, 13 andi, 14 slli, 15 srli, 16 srai, 17 slti, 18 sltiu
  - 19 lb, 20 lh, 21 lw, 22 lbu, 23 lhu, 24 sb, 25 sh, 26 sw
  - 27 beq, 28 bne, 29 blt, 30 bge, 31 bltu, 32 bgeu
  - 33 jal, 34 jalr, 35 lui, 36 auipc, 37 ecall, 38 ebreak, 39 fence
  - 40 mul, 41 mulh, 42 mulhu, 43 mulhsu, 44 div, 45 divu, 46 rem, 47 remu
- Exactly one bit is set per legal instruction.
- Decode is combinational from instr_in. The result is captured into the output register on the cycle the input is accepted (in_valid & in_ready).
- Latency: the bundle appears one cycle after acceptance.
- Output register load: when it is empty, or when out_valid & out_ready.
- Skid buffer:
  - If the output register is held (out_valid & !out_ready) while an input is accepted, the decoded bundle goes to the skid entry.
  - in_ready = !skid_valid, registered.
  - When the output drains, the skid entry moves to the output register on the same edge. A new input accepted on that edge then goes to the skid entry.
  - Throughput is 1/cycle with no bubbles while out_ready=1.
- Output is held stable while out_valid & !out_ready; no field may change.
- Immediates:
  - I-type: instr[31:20], sign-extended.
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {31, 7, 30:25, 11:8, 0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {31, 19:12, 20, 30:21, 0}.
  - R-type: 0.
- Shift-immediates: a funct7 other than 0000000 (slli/srli) or 0100000 (srai) is illegal.
- alu_enable is set for bits 0..18 and 40..47. rd_write is 0 for store, branch, ecall, ebreak and fence, or when rd=0.
- Illegal instructions: instructions=0, alu_enable=0, rd_write=0, illegal=1. The bundle is still presented with out_valid=1.
- Flush:
  - On the next edge, output and skid entries are invalidated; in_ready becomes 1.
  - Input presented on the flush cycle is dropped; flush takes priority over simultaneous acceptance.
- Reset, including mid-operation, clears both entries:
  - out_valid=0, in_ready=1 on the following cycle.
  - All data outputs = 0, illegal=0.

Decomposition:
- Package decoder_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM)
  - one-hot bit index constants OPV_* and OPV_W
  - a packed struct decoded_t carrying the output bundle fields
- Sub-module decode_comb: purely combinational, maps instr_in and pc_in to decoded_t. The top-level holds the output and skid registers plus handshake logic.

Test Plan:
- 0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle: instructions=0x1, rs1=1, rs2=2, rd=3, alu_enable=1, rd_write=1.
- 0xFFF00293 (addi x5,x0,-1) → instructions=0x400, imm=0xFFFFFFFF, rd=5. Then 0x40415093 (srai x1,x2,4) → instructions=0x10000, imm=0x00000404.
- 0x023100B3 (mul x1,x2,x3) → bit 40, i.e. 0x0100_0000_0000. Then 0x023170B3 (remu) → 0x8000_0000_0000, with alu_enable=1.
- 0xFFFFFFFF → illegal=1, instructions=0, rd_write=0, out_valid=1.
- out_ready=0, three back-to-back valid inputs:
  - first held on output, second in skid, in_ready=0 the cycle after the second is accepted;
  - third waits;
  - raise out_ready → bundles emerge in order with no loss or duplication.
- Skid full, then assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; the flush-cycle input never appears. Repeat with rst instead of flush → same result, and all data outputs are 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: opcodes, one-hot operation indices and the decoded bundle type for the RV32IM decode stage
package decoder_pkg;
    localparam int XLEN  = 32;
    localparam int OPV_W = 48;
    localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LOAD = 7'b0000011,
        STORE = 7'b0100011, BRANCH = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
        LUI = 7'b0110111, AUIPC = 7'b0010111, SYSTEM = 7'b1110011, MISC_MEM = 7'b0001111;
    typedef logic [5:0] opv_idx_t;
    localparam opv_idx_t OPV_ADD = 6'd0, OPV_SUB = 6'd1, OPV_XOR = 6'd2, OPV_OR = 6'd3,
        OPV_AND = 6'd4, OPV_SLL = 6'd5, OPV_SRL = 6'd6, OPV_SRA = 6'd7, OPV_SLT = 6'd8,
        OPV_SLTU = 6'd9, OPV_ADDI = 6'd10, OPV_XORI = 6'd11, OPV_ORI = 6'd12,
        OPV_ANDI = 6'd13, OPV_SLLI = 6'd14, OPV_SRLI = 6'd15, OPV_SRAI = 6'd16,
        OPV_SLTI = 6'd17, OPV_SLTIU = 6'd18, OPV_LB = 6'd19, OPV_LH = 6'd20,
        OPV_LW = 6'd21, OPV_LBU = 6'd22, OPV_LHU = 6'd23, OPV_SB = 6'd24, OPV_SH = 6'd25,
        OPV_SW = 6'd26, OPV_BEQ = 6'd27, OPV_BNE = 6'd28, OPV_BLT = 6'd29,
        OPV_BGE = 6'd30, OPV_BLTU = 6'd31, OPV_BGEU = 6'd32, OPV_JAL = 6'd33,
        OPV_JALR = 6'd34, OPV_LUI = 6'd35, OPV_AUIPC = 6'd36, OPV_ECALL = 6'd37,
        OPV_EBREAK = 6'd38, OPV_FENCE = 6'd39, OPV_MUL = 6'd40, OPV_MULH = 6'd41,
        OPV_MULHU = 6'd42, OPV_MULHSU = 6'd43, OPV_DIV = 6'd44, OPV_DIVU = 6'd45,
        OPV_REM = 6'd46, OPV_REMU = 6'd47;
    // funct3-indexed lookup tables; unused load/branch slots are rejected by the decoder
    localparam opv_idx_t OP_MAP [8] = '{OPV_ADD, OPV_SLL, OPV_SLT, OPV_SLTU,
                                        OPV_XOR, OPV_SRL, OPV_OR, OPV_AND};
    localparam opv_idx_t OPM_MAP [8] = '{OPV_MUL, OPV_MULH, OPV_MULHSU, OPV_MULHU,
                                         OPV_DIV, OPV_DIVU, OPV_REM, OPV_REMU};
    localparam opv_idx_t OPI_MAP [8] = '{OPV_ADDI, OPV_SLLI, OPV_SLTI, OPV_SLTIU,
                                         OPV_XORI, OPV_SRLI, OPV_ORI, OPV_ANDI};
    localparam opv_idx_t LD_MAP [8] = '{OPV_LB, OPV_LH, OPV_LW, OPV_LB,
                                        OPV_LBU, OPV_LHU, OPV_LB, OPV_LB};
    localparam opv_idx_t BR_MAP [8] = '{OPV_BEQ, OPV_BNE, OPV_BEQ, OPV_BEQ,
                                        OPV_BLT, OPV_BGE, OPV_BLTU, OPV_BGEU};
    typedef struct packed {
        logic [OPV_W-1:0] instructions;
        logic [4:0]       rs1_addr;
        logic [4:0]       rs2_addr;
        logic [4:0]       rd_addr;
        logic [XLEN-1:0]  imm;
        logic             alu_enable;
        logic             rd_write;
        logic             illegal;
        logic [XLEN-1:0]  pc;
    } decoded_t;
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32IM instruction word to decoded bundle
module decode_comb
    import decoder_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output decoded_t        o_dec
);
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_rd;
    logic       w_ok;
    opv_idx_t   w_idx;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
    assign w_op = i_instr[6:0];
    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];
    assign w_rd = i_instr[11:7];
    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    always_comb begin
        w_ok  = 1'b0;
        w_idx = OPV_ADD;
        w_imm = '0;
        case (w_op)
            OP: begin
                w_ok  = w_f7 == 7'h00 || w_f7 == 7'h01 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5));
                w_idx = w_f7 == 7'h01 ? OPM_MAP[w_f3] : w_f7 == 7'h20 ? (w_f3 == 3'd5 ? OPV_SRA : OPV_SUB) : OP_MAP[w_f3];
            end
            OP_IMM: begin
                w_ok  = w_f3 == 3'd1 ? w_f7 == 7'h00 : w_f3 == 3'd5 ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1;
                w_idx = (w_f3 == 3'd5 && w_f7[5]) ? OPV_SRAI : OPI_MAP[w_f3];
                w_imm = w_imm_i;
            end
            LOAD: begin
                w_ok  = w_f3 != 3'd3 && w_f3 < 3'd6;
                w_idx = LD_MAP[w_f3];
                w_imm = w_imm_i;
            end
            STORE: begin
                w_ok  = w_f3 < 3'd3;
                w_idx = OPV_SB + {3'b0, w_f3};
                w_imm = w_imm_s;
            end
            BRANCH: begin
                w_ok  = w_f3 != 3'd2 && w_f3 != 3'd3;
                w_idx = BR_MAP[w_f3];
                w_imm = w_imm_b;
            end
            JAL: begin
                w_ok  = 1'b1;
                w_idx = OPV_JAL;
                w_imm = w_imm_j;
            end
            JALR: begin
                w_ok  = w_f3 == 3'd0;
                w_idx = OPV_JALR;
                w_imm = w_imm_i;
            end
            LUI, AUIPC: begin
                w_ok  = 1'b1;
                w_idx = w_op == LUI ? OPV_LUI : OPV_AUIPC;
                w_imm = w_imm_u;
            end
            SYSTEM: begin
                w_ok  = i_instr == 32'h0000_0073 || i_instr == 32'h0010_0073;
                w_idx = i_instr[20] ? OPV_EBREAK : OPV_ECALL;
                w_imm = w_imm_i;
            end
            MISC_MEM: begin
                w_ok  = w_f3 == 3'd0;
                w_idx = OPV_FENCE;
                w_imm = w_imm_i;
            end
            default: w_ok = 1'b0;
        endcase
    end
    always_comb begin
        o_dec              = '0;
        o_dec.instructions = w_ok ? {{(OPV_W-1){1'b0}}, 1'b1} << w_idx : '0;
        o_dec.rs1_addr     = i_instr[19:15];
        o_dec.rs2_addr     = i_instr[24:20];
        o_dec.rd_addr      = w_rd;
        o_dec.imm          = w_imm;
        o_dec.alu_enable   = w_ok && (w_idx <= OPV_SLTIU || w_idx >= OPV_MUL);
        o_dec.rd_write     = w_ok && w_rd != 5'd0 && !((w_idx >= OPV_SB && w_idx <= OPV_BGEU) || (w_idx >= OPV_ECALL && w_idx <= OPV_FENCE));
        o_dec.illegal      = !w_ok;
        o_dec.pc           = i_pc;
    end
endmodule

// File: rtl/instr_decoder.sv
// instr_decoder: registered RV32IM decode stage with a 2-entry skid buffer on a valid/ready pipe
module instr_decoder
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPV_W-1:0] instructions,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic [XLEN-1:0]  imm,
    output logic             alu_enable,
    output logic             rd_write,
    output logic [XLEN-1:0]  pc_out,
    output logic             illegal
);
    decoded_t w_dec, r_out, r_skid;
    logic r_out_valid, r_skid_valid, r_in_ready;
    logic w_acc, w_load, w_skid_nv;
    decode_comb u_decode (.i_instr(instr_in), .i_pc(pc_in), .o_dec(w_dec));
    assign w_acc     = in_valid && r_in_ready && !flush;
    assign w_load    = !r_out_valid || out_ready;
    // skid only fills when the output is held; a draining output always takes the skid entry first
    assign w_skid_nv = !w_load && (r_skid_valid || w_acc);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_out_valid  <= w_load ? (r_skid_valid || w_acc) : 1'b1;
            r_skid_valid <= w_skid_nv;
            r_in_ready   <= !w_skid_nv;
            if (w_load && (r_skid_valid || w_acc))
                r_out <= r_skid_valid ? r_skid : w_dec;
            if (!w_load && w_acc)
                r_skid <= w_dec;
        end
    end
    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign instructions = r_out.instructions;
    assign rs1_addr     = r_out.rs1_addr;
    assign rs2_addr     = r_out.rs2_addr;
    assign rd_addr      = r_out.rd_addr;
    assign imm          = r_out.imm;
    assign alu_enable   = r_out.alu_enable;
    assign rd_write     = r_out.rd_write;
    assign pc_out       = r_out.pc;
    assign illegal      = r_out.illegal;
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: directed vectors plus an opcode-table reference model with an in-order scoreboard
module tb_instr_decoder;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, alu_enable, rd_write, illegal;
    logic [31:0] instr_in = '0, pc_in = '0, imm, pc_out;
    logic [47:0] instructions;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    int n_checks = 0, n_fail = 0;
    logic rnd_ready = 1'b0;

    typedef struct packed {
        logic [47:0] ops;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        alu, wr, ill;
        logic [31:0] pc;
    } exp_t;
    exp_t q[$];

    instr_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
        .pc_in(pc_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .instructions(instructions), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .imm(imm), .alu_enable(alu_enable), .rd_write(rd_write), .pc_out(pc_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // reference: RV32IM opcode table by mask/match, then format-by-operation for the immediate
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int k;
        casez (w)
            32'b0000000_?????_?????_000_?????_0110011: k = 0;
            32'b0100000_?????_?????_000_?????_0110011: k = 1;
            32'b0000000_?????_?????_100_?????_0110011: k = 2;
            32'b0000000_?????_?????_110_?????_0110011: k = 3;
            32'b0000000_?????_?????_111_?????_0110011: k = 4;
            32'b0000000_?????_?????_001_?????_0110011: k = 5;
            32'b0000000_?????_?????_101_?????_0110011: k = 6;
            32'b0100000_?????_?????_101_?????_0110011: k = 7;
            32'b0000000_?????_?????_010_?????_0110011: k = 8;
            32'b0000000_?????_?????_011_?????_0110011: k = 9;
            32'b????????????_?????_000_?????_0010011:  k = 10;
            32'b????????????_?????_100_?????_0010011:  k = 11;
            32'b????????????_?????_110_?????_0010011:  k = 12;
            32'b????????????_?????_111_?????_0010011:  k = 13;
            32'b0000000_?????_?????_001_?????_0010011: k = 14;
            32'b0000000_?????_?????_101_?????_0010011: k = 15;
            32'b0100000_?????_?????_101_?????_0010011: k = 16;
            32'b????????????_?????_010_?????_0010011:  k = 17;
            32'b????????????_?????_011_?????_0010011:  k = 18;
            32'b????????????_?????_000_?????_0000011:  k = 19;
            32'b????????????_?????_001_?????_0000011:  k = 20;
            32'b????????????_?????_010_?????_0000011:  k = 21;
            32'b????????????_?????_100_?????_0000011:  k = 22;
            32'b????????????_?????_101_?????_0000011:  k = 23;
            32'b????????????_?????_000_?????_0100011:  k = 24;
            32'b????????????_?????_001_?????_0100011:  k = 25;
            32'b????????????_?????_010_?????_0100011:  k = 26;
            32'b????????????_?????_000_?????_1100011:  k = 27;
            32'b????????????_?????_001_?????_1100011:  k = 28;
            32'b????????????_?????_100_?????_1100011:  k = 29;
            32'b????????????_?????_101_?????_1100011:  k = 30;
            32'b????????????_?????_110_?????_1100011:  k = 31;
            32'b????????????_?????_111_?????_1100011:  k = 32;
            {25'b?, 7'b1101111}:                       k = 33;
            32'b????????????_?????_000_?????_1100111:  k = 34;
            {25'b?, 7'b0110111}:                       k = 35;
            {25'b?, 7'b0010111}:                       k = 36;
            32'h0000_0073:                             k = 37;
            32'h0010_0073:                             k = 38;
            32'b????????????_?????_000_?????_0001111:  k = 39;
            32'b0000001_?????_?????_000_?????_0110011: k = 40;
            32'b0000001_?????_?????_001_?????_0110011: k = 41;
            32'b0000001_?????_?????_011_?????_0110011: k = 42;
            32'b0000001_?????_?????_010_?????_0110011: k = 43;
            32'b0000001_?????_?????_100_?????_0110011: k = 44;
            32'b0000001_?????_?????_101_?????_0110011: k = 45;
            32'b0000001_?????_?????_110_?????_0110011: k = 46;
            32'b0000001_?????_?????_111_?????_0110011: k = 47;
            default:                                   k = -1;
        endcase
        e.ill = k < 0;
        e.ops = '0;
        if (!e.ill) e.ops[k] = 1'b1;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        if (k inside {[24:26]}) e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        else if (k inside {[27:32]}) e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        else if (k == 33) e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        else if (k == 35 || k == 36) e.imm = {w[31:12], 12'b0};
        else if (k inside {[0:9], [40:47]}) e.imm = '0;
        else e.imm = {{20{w[31]}}, w[31:20]};
        e.alu = !e.ill && (k <= 18 || k >= 40);
        e.wr  = !e.ill && w[11:7] != 5'd0 && !(k inside {[24:32], [37:39]});
        e.pc  = pc;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // compare process: inputs and outputs are stable at the falling edge
    always @(negedge clk) begin
        exp_t a, e;
        if (!rst && out_valid) begin
            a = {instructions, rs1_addr, rs2_addr, rd_addr, imm, alu_enable, rd_write, illegal, pc_out};
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got bundle %h expected none", a);
            end else begin
                e = q[0];
                if (e.ill) a.imm = e.imm;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL bundle: got %h expected %h", a, e);
                end
            end
        end
        if (rst || flush) q.delete();
        else begin
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(instr_in, pc_in));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic push(input logic [31:0] w);
        int t;
        in_valid = 1'b1;
        instr_in = w;
        pc_in    = pc_in + 32'd4;
        for (t = 0; t < 50 && !in_ready; t++) step();
        if (!in_ready) chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] sweep [14] = '{32'h00112223, 32'hFE208EE3, 32'h008000EF, 32'h123452B7,
                                32'h00001517, 32'h00000073, 32'h00100073, 32'h0FF0000F,
                                32'h000080E7, 32'hFFC12183, 32'h0010B193, 32'h02009093,
                                32'h00003003, 32'h0220C1B3};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step(2);
        rst = 1'b0;
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset_instructions", {16'b0, instructions}, 64'd0);
        chk("reset_illegal", {63'b0, illegal}, 64'd0);

        push(32'h002081B3);
        chk("add_valid", {63'b0, out_valid}, 64'd1);
        chk("add_ops", {16'b0, instructions}, 64'h1);
        chk("add_regs", {49'b0, rs1_addr, rs2_addr, rd_addr}, {49'b0, 5'd1, 5'd2, 5'd3});
        chk("add_flags", {62'b0, alu_enable, rd_write}, 64'd3);
        push(32'hFFF00293);
        chk("addi_ops", {16'b0, instructions}, 64'h400);
        chk("addi_imm", {32'b0, imm}, 64'hFFFFFFFF);
        chk("addi_rd", {59'b0, rd_addr}, 64'd5);
        push(32'h40415093);
        chk("srai_ops", {16'b0, instructions}, 64'h10000);
        chk("srai_imm", {32'b0, imm}, 64'h404);
        push(32'h023100B3);
        chk("mul_ops", {16'b0, instructions}, 64'h0100_0000_0000);
        push(32'h023170B3);
        chk("remu_ops", {16'b0, instructions}, 64'h8000_0000_0000);
        chk("remu_alu", {63'b0, alu_enable}, 64'd1);
        push(32'hFFFFFFFF);
        chk("ill_flag", {63'b0, illegal}, 64'd1);
        chk("ill_ops", {16'b0, instructions}, 64'd0);
        chk("ill_wr_valid", {62'b0, rd_write, out_valid}, 64'd1);
        push(32'h40000033);
        chk("sub_x0_wr", {62'b0, rd_write, alu_enable}, 64'd1);
        push(32'h02009093);
        chk("slli_bad_f7", {63'b0, illegal}, 64'd1);
        push(32'h00000073);
        chk("ecall_ops_wr", {15'b0, instructions, rd_write}, {15'b0, 48'h20_0000_0000, 1'b0});
        step();

        out_ready = 1'b0;
        push(32'h002081B3);
        push(32'h0220C1B3);
        chk("skid_full_in_ready", {63'b0, in_ready}, 64'd0);
        in_valid = 1'b1;
        instr_in = 32'h123452B7;
        pc_in    = pc_in + 32'd4;
        step(3);
        chk("held_ops", {16'b0, instructions}, 64'h1);
        chk("held_in_ready", {62'b0, in_ready, out_valid}, 64'd1);
        out_ready = 1'b1;
        for (int t = 0; t < 10 && !in_ready; t++) step();
        step();
        in_valid = 1'b0;
        step(3);
        chk("drain_empty", {63'b0, out_valid}, 64'd0);
        chk("drain_queue", 64'(q.size()), 64'd0);

        rnd_ready = 1'b1;
        foreach (sweep[i]) push(sweep[i]);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        step(4);
        chk("sweep_drained", 64'(q.size()), 64'd0);

        out_ready = 1'b0;
        push(32'h002081B3);
        push(32'h023100B3);
        in_valid = 1'b1;
        instr_in = 32'hFFF00293;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_state", {62'b0, out_valid, in_ready}, 64'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step(2);
        chk("flush_drop", {62'b0, out_valid, in_ready}, 64'd1);

        out_ready = 1'b0;
        push(32'h002081B3);
        push(32'h023100B3);
        in_valid = 1'b1;
        instr_in = 32'hFFF00293;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_state", {62'b0, out_valid, in_ready}, 64'd1);
        chk("rst_data", {instructions, rd_addr, rs1_addr, illegal, rd_write, alu_enable},
            64'd0);
        chk("rst_imm_pc", {imm, pc_out}, 64'd0);
        step(2);
        chk("rst_drop", {63'b0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
